// File: rtl/matriz_botoes_leitor.sv
// Button reader for the LED-matrix puzzle: synchronizes, debounces and edge-detects
// eight push-buttons, producing one toggle request per press plus move/debug outputs.
module matriz_botoes_leitor #(
  parameter int unsigned DEBOUNCE_CICLOS = 50000,
  parameter int unsigned CONT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] botoes_brutos,
  input  logic       habilita,
  input  logic       limpa_jogadas,
  output logic [7:0] botoes_pulso,
  output logic [7:0] botoes_estavel,
  output logic [7:0] jogadas,
  output logic [2:0] db_tecla,
  output logic       db_pulso
);

  localparam int unsigned N = 8;
  localparam logic [CONT_W-1:0] CNT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [7:0] JOGADAS_MAX = 8'hFF;

  typedef enum logic [1:0] {
    EST0   = 2'd0,
    CONTA1 = 2'd1,
    EST1   = 2'd2,
    CONTA0 = 2'd3
  } estado_t;

  logic [N-1:0] sync1_q, sync2_q;
  logic [N-1:0] aceita_c;
  logic [N-1:0] pulso_q, pulso_d;
  logic [7:0]   jogadas_q, jogadas_d;
  logic [2:0]   tecla_q, tecla_d;

  // Two-flop synchronizer on the raw asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= botoes_brutos;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_debounce
    estado_t           estado_q, estado_d;
    logic [CONT_W-1:0] cnt_q, cnt_d;
    logic              est_q, est_d;
    logic              aceita_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        estado_q <= EST0;
        cnt_q    <= '0;
        est_q    <= 1'b0;
      end else begin
        estado_q <= estado_d;
        cnt_q    <= cnt_d;
        est_q    <= est_d;
      end
    end

    // aceita_d flags a press accepted at this edge; releases never flag
    always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      est_d    = est_q;
      aceita_d = 1'b0;
      unique case (estado_q)
        EST0: begin
          if (sync2_q[g]) begin
            estado_d = CONTA1;
            cnt_d    = '0;
          end
        end
        CONTA1: begin
          if (!sync2_q[g]) begin
            estado_d = EST0;
            cnt_d    = '0;
          end else if (cnt_q == CNT_MAX) begin
            estado_d = EST1;
            est_d    = 1'b1;
            aceita_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CONT_W'(1);
          end
        end
        EST1: begin
          if (!sync2_q[g]) begin
            estado_d = CONTA0;
            cnt_d    = '0;
          end
        end
        CONTA0: begin
          if (sync2_q[g]) begin
            estado_d = EST1;
            cnt_d    = '0;
          end else if (cnt_q == CNT_MAX) begin
            estado_d = EST0;
            est_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CONT_W'(1);
          end
        end
        default: begin
          estado_d = EST0;
          cnt_d    = '0;
        end
      endcase
    end

    assign aceita_c[g]       = aceita_d;
    assign botoes_estavel[g] = est_q;
  end

  // Pulses, move counter and last-key register
  always_comb begin
    pulso_d   = habilita ? aceita_c : '0;
    jogadas_d = jogadas_q;
    tecla_d   = tecla_q;
    if (limpa_jogadas) begin
      jogadas_d = '0;
    end else if ((pulso_q != '0) && (jogadas_q != JOGADAS_MAX)) begin
      jogadas_d = jogadas_q + 8'd1;
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (pulso_q[i]) tecla_d = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulso_q   <= '0;
      jogadas_q <= '0;
      tecla_q   <= '0;
    end else begin
      pulso_q   <= pulso_d;
      jogadas_q <= jogadas_d;
      tecla_q   <= tecla_d;
    end
  end

  assign botoes_pulso = pulso_q;
  assign jogadas      = jogadas_q;
  assign db_tecla     = tecla_q;
  assign db_pulso     = |pulso_q;

endmodule

// File: tb/tb_matriz_botoes_leitor.sv
// Directed self-checking bench for matriz_botoes_leitor with DEBOUNCE_CICLOS=4.
module tb_matriz_botoes_leitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] botoes_brutos;
  logic       habilita;
  logic       limpa_jogadas;
  logic [7:0] botoes_pulso;
  logic [7:0] botoes_estavel;
  logic [7:0] jogadas;
  logic [2:0] db_tecla;
  logic       db_pulso;

  int checks = 0;
  int errors = 0;
  int np;

  matriz_botoes_leitor #(.DEBOUNCE_CICLOS(4), .CONT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .botoes_brutos (botoes_brutos),
    .habilita      (habilita),
    .limpa_jogadas (limpa_jogadas),
    .botoes_pulso  (botoes_pulso),
    .botoes_estavel(botoes_estavel),
    .jogadas       (jogadas),
    .db_tecla      (db_tecla),
    .db_pulso      (db_pulso)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance n edges, counting cycles on which any pulse is visible
  task automatic tick_count(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (botoes_pulso != 8'h00) cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; botoes_brutos = 8'h00; habilita = 1'b1; limpa_jogadas = 1'b0;
    tick(3);
    chk("rst_pulso", 32'(botoes_pulso), 32'h00);
    chk("rst_estavel", 32'(botoes_estavel), 32'h00);
    chk("rst_jogadas", 32'(jogadas), 32'h00);
    chk("rst_tecla", 32'(db_tecla), 32'h0);
    chk("rst_dbpulso", 32'(db_pulso), 32'h0);
    rst = 1'b0;
    tick(2);

    // Clean press on bit 0
    botoes_brutos = 8'h01;
    tick_count(6, np);
    chk("t1_nopulse_early", 32'(np), 32'd0);
    chk("t1_estavel_early", 32'(botoes_estavel), 32'h00);
    tick(1);
    chk("t1_pulso_e7", 32'(botoes_pulso), 32'h01);
    chk("t1_dbpulso_e7", 32'(db_pulso), 32'h1);
    chk("t1_estavel_e7", 32'(botoes_estavel), 32'h01);
    chk("t1_jogadas_e7", 32'(jogadas), 32'd0);
    tick(1);
    chk("t1_pulso_e8", 32'(botoes_pulso), 32'h00);
    chk("t1_jogadas_e8", 32'(jogadas), 32'd1);
    chk("t1_tecla", 32'(db_tecla), 32'd0);
    tick_count(100, np);
    chk("t1_hold_nopulse", 32'(np), 32'd0);
    botoes_brutos = 8'h00;
    tick_count(6, np);
    chk("t1_rel_estavel_early", 32'(botoes_estavel), 32'h01);
    tick(1);
    chk("t1_rel_estavel", 32'(botoes_estavel), 32'h00);
    tick_count(5, np);
    chk("t1_rel_nopulse", 32'(np), 32'd0);

    // Bounce on bit 3
    limpa_jogadas = 1'b1;
    tick(1);
    limpa_jogadas = 1'b0;
    chk("t2_clear", 32'(jogadas), 32'd0);
    botoes_brutos = 8'h08; tick_count(2, np);
    chk("t2_b1", 32'(np), 32'd0);
    botoes_brutos = 8'h00; tick_count(2, np);
    chk("t2_b2", 32'(np), 32'd0);
    botoes_brutos = 8'h08; tick_count(2, np);
    chk("t2_b3", 32'(np), 32'd0);
    botoes_brutos = 8'h00; tick_count(2, np);
    chk("t2_b4", 32'(np), 32'd0);
    botoes_brutos = 8'h08;
    tick_count(6, np);
    chk("t2_nopulse_early", 32'(np), 32'd0);
    chk("t2_estavel_early", 32'(botoes_estavel), 32'h00);
    tick(1);
    chk("t2_pulso", 32'(botoes_pulso), 32'h08);
    tick(1);
    chk("t2_jogadas", 32'(jogadas), 32'd1);
    chk("t2_tecla", 32'(db_tecla), 32'd3);
    botoes_brutos = 8'h00;
    tick(10);

    // Simultaneous press with clear at the increment edge
    botoes_brutos = 8'h0A;
    tick(7);
    chk("t3_pulso", 32'(botoes_pulso), 32'h0A);
    limpa_jogadas = 1'b1;
    tick(1);
    limpa_jogadas = 1'b0;
    chk("t3_pulso_drop", 32'(botoes_pulso), 32'h00);
    chk("t3_jogadas", 32'(jogadas), 32'd0);
    chk("t3_tecla", 32'(db_tecla), 32'd1);
    botoes_brutos = 8'h00;
    tick(10);

    // Gating by habilita
    habilita = 1'b0;
    botoes_brutos = 8'h80;
    tick_count(7, np);
    chk("t4_gated_nopulse", 32'(np), 32'd0);
    chk("t4_gated_estavel", 32'(botoes_estavel), 32'h80);
    habilita = 1'b1;
    tick_count(20, np);
    chk("t4_no_repulse", 32'(np), 32'd0);
    botoes_brutos = 8'h00;
    tick(10);
    chk("t4_released", 32'(botoes_estavel), 32'h00);
    botoes_brutos = 8'h80;
    tick_count(6, np);
    chk("t4_nopulse_early", 32'(np), 32'd0);
    tick(1);
    chk("t4_pulso", 32'(botoes_pulso), 32'h80);
    tick(1);
    chk("t4_jogadas", 32'(jogadas), 32'd1);
    chk("t4_tecla", 32'(db_tecla), 32'd7);
    botoes_brutos = 8'h00;
    tick(10);

    // Reset mid-count with a held button
    botoes_brutos = 8'h01;
    tick(5);
    rst = 1'b1;
    #1;
    chk("t5_rst_jogadas", 32'(jogadas), 32'd0);
    chk("t5_rst_tecla", 32'(db_tecla), 32'd0);
    chk("t5_rst_estavel", 32'(botoes_estavel), 32'h00);
    chk("t5_rst_pulso", 32'(botoes_pulso), 32'h00);
    tick(2);
    rst = 1'b0;
    tick_count(6, np);
    chk("t5_nopulse_early", 32'(np), 32'd0);
    tick(1);
    chk("t5_pulso_e7", 32'(botoes_pulso), 32'h01);
    tick(1);
    chk("t5_jogadas", 32'(jogadas), 32'd1);
    botoes_brutos = 8'h00;
    tick(8);

    // Saturation over 300 press/release cycles
    begin
      int total = 0;
      for (int i = 0; i < 300; i++) begin
        botoes_brutos = 8'h01;
        tick_count(8, np);
        total += np;
        botoes_brutos = 8'h00;
        tick(8);
        if (i == 99) chk("t5_jogadas_101", 32'(jogadas), 32'd101);
      end
      chk("t5_total_pulses", 32'(total), 32'd300);
    end
    chk("t5_saturated", 32'(jogadas), 32'd255);
    limpa_jogadas = 1'b1;
    tick(1);
    limpa_jogadas = 1'b0;
    chk("t5_cleared", 32'(jogadas), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
